// File: rtl/seq_detector_param.sv
// ---------------------------------------------------------------------------
// seq_detector_param
//
// Serial bit-pattern detector. It accepts one bit per edge while in_valid is
// high and keeps the most recent PAT_LEN bits. It pulses `out` for one cycle
// whenever those bits equal the pattern register. The pattern can be reloaded
// at runtime. Overlapping or non-overlapping detection is chosen per accepted
// bit by the `overlap` input.
//
// Build option:
//   SEQ_DET_COUNT_EN : when defined, a saturating match counter drives
//                      match_count and count_clr clears it. When undefined,
//                      no counter is built, match_count is tied to 0 and
//                      count_clr is ignored.
//
// Ports:
//   clk         : clock, all state updates on the rising edge
//   reset       : synchronous active-high reset, overrides every other input
//   in          : serial data bit
//   in_valid    : `in` is accepted only on edges where this is 1
//   overlap     : 1 = overlapping detection, 0 = non-overlapping
//   pat_load    : load pat_in into the pattern register (drops this edge's bit)
//   pat_in      : new pattern, MSB is the first bit received
//   count_clr   : synchronous clear of match_count (clear then count)
//   out         : registered one-cycle match pulse
//   match_count : saturating number of matches
// ---------------------------------------------------------------------------
module seq_detector_param #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
  parameter int                 CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in,
  input  logic               in_valid,
  input  logic               overlap,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
  input  logic               count_clr,
  output logic               out,
  output logic [CNT_W-1:0]   match_count
);

  localparam int FILL_W = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN);

  logic [PAT_LEN-1:0] pat_q,  pat_d;
  logic [PAT_LEN-1:0] hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               out_q,  out_d;

  logic [PAT_LEN-1:0] nh;
  logic [FILL_W-1:0]  nf;
  logic               hit;

  // Candidate history and fill level if the current bit were accepted.
  assign nh = {hist_q[PAT_LEN-2:0], in};
  assign nf = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + 1'b1;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    out_d  = 1'b0;
    hit    = 1'b0;
    if (pat_load) begin
      // A load restarts detection from scratch; the bit on this edge is lost.
      pat_d  = pat_in;
      hist_d = '0;
      fill_d = '0;
    end else if (in_valid) begin
      hit    = (nf == FILL_MAX) && (nh == pat_q);
      hist_d = nh;
      out_d  = hit;
      // Non-overlapping mode forces the next match to use PAT_LEN fresh bits.
      fill_d = (hit && !overlap) ? '0 : nf;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q  <= PATTERN;
      hist_q <= '0;
      fill_q <= '0;
      out_q  <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      out_q  <= out_d;
    end
  end

  assign out = out_q;

`ifdef SEQ_DET_COUNT_EN
  logic [CNT_W-1:0] count_q, count_d;

  // Clear has priority, but a hit on the same edge still counts (result 1).
  always_comb begin
    count_d = count_q;
    if (count_clr) begin
      count_d = hit ? CNT_W'(1) : '0;
    end else if (hit && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign match_count = count_q;
`else
  logic unused_count_clr;
  assign unused_count_clr = count_clr;
  assign match_count      = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// ---------------------------------------------------------------------------
// tb_seq_detector_param
//
// Two detectors share all inputs: one uses the default 8-bit counter and the
// other a 2-bit counter, which makes saturation easy to reach. Vectors come
// from a table that holds each expected `out`. A small counter model derives
// the expected match_count values from those expected pulses. Expectations are
// queued when a vector is driven and popped after the edge that produces them.
// ---------------------------------------------------------------------------
module tb_seq_detector_param;

`ifdef SEQ_DET_COUNT_EN
  localparam bit COUNT_EN = 1'b1;
`else
  localparam bit COUNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, in, in_valid, overlap, pat_load, count_clr;
  logic [3:0] pat_in;
  logic       out_a, out_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  always #5 clk = ~clk;

  seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1101), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .count_clr(count_clr),
    .out(out_a), .match_count(cnt_a)
  );

  seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1101), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .count_clr(count_clr),
    .out(out_b), .match_count(cnt_b)
  );

  typedef struct {
    bit       rst;
    bit       vld;
    bit       b;
    bit       ov;
    bit       ld;
    bit [3:0] pi;
    bit       clr;
    bit       exp_out;
  } vec_t;

  typedef struct {
    bit       out;
    int       c8;
    int       c2;
    string    tag;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   m_c8   = 0;
  int   m_c2   = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Table helpers.
  function automatic void t_rst(input bit ld = 1'b0);
    tbl.push_back('{rst:1, vld:1, b:1, ov:1, ld:ld, pi:4'b0000, clr:0, exp_out:0});
  endfunction
  function automatic void t_bit(input bit b, input bit ov, input bit e,
                                input bit clr = 1'b0);
    tbl.push_back('{rst:0, vld:1, b:b, ov:ov, ld:0, pi:4'b0000, clr:clr, exp_out:e});
  endfunction
  function automatic void t_idle(input bit b);
    tbl.push_back('{rst:0, vld:0, b:b, ov:1, ld:0, pi:4'b0000, clr:0, exp_out:0});
  endfunction
  function automatic void t_load(input bit [3:0] pi, input bit vld, input bit b);
    tbl.push_back('{rst:0, vld:vld, b:b, ov:1, ld:1, pi:pi, clr:0, exp_out:0});
  endfunction

  // Drive one vector, queue its expectation, and check after the edge.
  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    bit   hit;
    @(negedge clk);
    reset     = v.rst;
    in_valid  = v.vld;
    in        = v.b;
    overlap   = v.ov;
    pat_load  = v.ld;
    pat_in    = v.pi;
    count_clr = v.clr;
    hit = v.exp_out && v.vld && !v.ld && !v.rst;
    if (v.rst) begin
      m_c8 = 0;
      m_c2 = 0;
    end else if (v.clr) begin
      m_c8 = hit ? 1 : 0;
      m_c2 = hit ? 1 : 0;
    end else if (hit) begin
      if (m_c8 < 255) m_c8++;
      if (m_c2 < 3)   m_c2++;
    end
    e.out = v.exp_out;
    e.c8  = COUNT_EN ? m_c8 : 0;
    e.c2  = COUNT_EN ? m_c2 : 0;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, " out_a"}, int'(out_a), int'(e.out));
    check({e.tag, " out_b"}, int'(out_b), int'(e.out));
    check({e.tag, " cnt8"},  int'(cnt_a), e.c8);
    check({e.tag, " cnt2"},  int'(cnt_b), e.c2);
  endtask

  initial begin
    vec_t v;
    reset = 1'b1; in = 1'b0; in_valid = 1'b0; overlap = 1'b1;
    pat_load = 1'b0; pat_in = '0; count_clr = 1'b0;

    // Reset state.
    t_rst(); t_rst();
    // Overlap, default pattern 1101: pulses on bits 4 and 7.
    t_bit(1,1,0); t_bit(1,1,0); t_bit(0,1,0); t_bit(1,1,1);
    t_bit(1,1,0); t_bit(0,1,0); t_bit(1,1,1);
    // Non-overlap: pulse on bit 4 only, then 1,1,0,1 pulses again.
    t_rst();
    t_bit(1,0,0); t_bit(1,0,0); t_bit(0,0,0); t_bit(1,0,1);
    t_bit(1,0,0); t_bit(0,0,0); t_bit(1,0,0);
    t_bit(1,0,0); t_bit(1,0,0); t_bit(0,0,0); t_bit(1,0,1);
    // Idle edges clear out and hold history.
    t_idle(1); t_idle(0);
    // Runtime load of 0110 with a valid bit that must be dropped.
    t_load(4'b0110, 1, 1);
    t_bit(0,1,0); t_bit(1,1,0); t_bit(1,1,0); t_bit(0,1,1);
    t_bit(1,1,0); t_bit(1,1,0); t_bit(0,1,1);
    // Fresh load, then 1,1,0,1 must not match 0110.
    t_load(4'b0110, 0, 0);
    t_bit(1,1,0); t_bit(1,1,0); t_bit(0,1,0); t_bit(1,1,0);
    // Reset mid-stream discards partial history and restores the pattern.
    t_rst();
    t_bit(1,1,0); t_bit(1,1,0); t_bit(0,1,0);
    t_rst();
    t_bit(1,1,0);
    t_bit(1,1,0); t_bit(1,1,0); t_bit(0,1,0); t_bit(1,1,1);
    // All-ones pattern: back-to-back hits saturate the 2-bit counter.
    t_rst();
    t_load(4'b1111, 0, 0);
    t_bit(1,1,0); t_bit(1,1,0); t_bit(1,1,0);
    t_bit(1,1,1); t_bit(1,1,1); t_bit(1,1,1); t_bit(1,1,1); t_bit(1,1,1);
    // Clear on a hit edge gives 1.
    t_bit(1,1,1,1);
    // Switch to non-overlap: this hit restarts fill, so the next 3 miss.
    t_bit(1,0,1);
    t_bit(1,0,0); t_bit(1,0,0); t_bit(1,0,0);
    t_bit(1,1,1);
    // Clear without a hit gives 0.
    t_bit(0,1,0,1);
    // Reset overrides a simultaneous load: default pattern is back.
    t_rst(1'b1);
    t_bit(1,1,0); t_bit(1,1,0); t_bit(0,1,0); t_bit(1,1,1);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Valid gating: random bubbles with `in` toggling between accepted bits.
    v = '{rst:1, vld:1, b:0, ov:1, ld:0, pi:4'b0000, clr:0, exp_out:0};
    apply(v, "gate_rst");
    for (int k = 0; k < 4; k++) begin
      int unsigned nb;
      bit          pat_bits [4];
      pat_bits = '{1'b1, 1'b1, 1'b0, 1'b1};
      nb = $urandom_range(3, 0);
      for (int j = 0; j < int'(nb); j++) begin
        v = '{rst:0, vld:0, b:((j % 2) == 0), ov:1, ld:0, pi:4'b0000, clr:0, exp_out:0};
        apply(v, $sformatf("gate_bub%0d_%0d", k, j));
      end
      v = '{rst:0, vld:1, b:pat_bits[k], ov:1, ld:0, pi:4'b0000, clr:0,
            exp_out:(k == 3)};
      apply(v, $sformatf("gate_bit%0d", k));
    end
    v = '{rst:0, vld:0, b:1, ov:1, ld:0, pi:4'b0000, clr:0, exp_out:0};
    apply(v, "gate_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
